// File: rtl/conn_setup_encoder.sv
// Turns one open/close connection request into a stream of ConnSetupFrame commands
// (frame layout: [66:64] cmd, [63:0] data) and returns one response per request.
module conn_setup_encoder #(
    parameter int NIC_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_open,
    input  logic [31:0] req_conn_id,
    input  logic [31:0] req_dest_ip,
    input  logic [15:0] req_dest_port,
    input  logic [15:0] req_client_flow_id,
    input  logic [15:0] req_qp_num,
    input  logic [15:0] req_p_key,
    input  logic [31:0] req_q_key,
    output logic        conn_setup_en_out,
    output logic [66:0] conn_setup_frame_out,
    input  logic        status_valid_in,
    input  logic        status_error_in,
    input  logic        parser_error_in,
    output logic        resp_valid,
    output logic [1:0]  resp_code,
    output logic        busy,
    output logic [7:0]  spurious_status_cnt
);

    localparam logic [2:0] CMD_CONN_ID   = 3'd1;
    localparam logic [2:0] CMD_OPEN      = 3'd2;
    localparam logic [2:0] CMD_DEST_IP   = 3'd3;
    localparam logic [2:0] CMD_DEST_PORT = 3'd4;
    localparam logic [2:0] CMD_FLOW_ID   = 3'd5;
    localparam logic [2:0] CMD_QP_FIELDS = 3'd6;
    localparam logic [2:0] CMD_ENABLE    = 3'd7;

    localparam logic [1:0] RESP_OK        = 2'd0;
    localparam logic [1:0] RESP_REJECTED  = 2'd1;
    localparam logic [1:0] RESP_TIMEOUT   = 2'd2;
    localparam logic [1:0] RESP_PARSE_ERR = 2'd3;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ST, RESP} state_t;

    state_t      state_q;
    logic [2:0]  frameIdx_q;
    logic        open_q;
    logic [31:0] destIp_q;
    logic [15:0] destPort_q;
    logic [15:0] flowId_q;
    logic [15:0] qpNum_q;
    logic [15:0] pKey_q;
    logic [31:0] qKey_q;
    logic [15:0] timer_q;
    logic        parserPrev_q;
    logic        reqReady_q;
    logic        en_q;
    logic [66:0] frame_q;
    logic        respValid_q;
    logic [1:0]  respCode_q;
    logic        busy_q;
    logic [7:0]  spurCnt_q;
    logic [66:0] nextFrame_d;
    logic        parserRise;
    logic        unusedNicId;

    // NIC_ID only labels simulation messages elsewhere; it has no hardware role.
    assign unusedNicId = (NIC_ID != 0);
    assign parserRise  = parser_error_in & ~parserPrev_q;

    // Frame to emit next; anything past the last payload frame is Enable.
    always_comb begin
        nextFrame_d = {CMD_ENABLE, 64'd0};
        if (open_q) begin
            case (frameIdx_q)
                3'd1:    nextFrame_d = {CMD_OPEN, 64'd1};
                3'd2:    nextFrame_d = {CMD_DEST_IP, 32'd0, destIp_q};
                3'd3:    nextFrame_d = {CMD_DEST_PORT, 48'd0, destPort_q};
                3'd4:    nextFrame_d = {CMD_FLOW_ID, 48'd0, flowId_q};
                3'd5:    nextFrame_d = {CMD_QP_FIELDS, qpNum_q, pKey_q, qKey_q};
                default: ;
            endcase
        end else if (frameIdx_q == 3'd1) begin
            nextFrame_d = {CMD_OPEN, 64'd0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            frameIdx_q   <= '0;
            open_q       <= 1'b0;
            destIp_q     <= '0;
            destPort_q   <= '0;
            flowId_q     <= '0;
            qpNum_q      <= '0;
            pKey_q       <= '0;
            qKey_q       <= '0;
            timer_q      <= '0;
            parserPrev_q <= 1'b0;
            reqReady_q   <= 1'b0;
            en_q         <= 1'b0;
            frame_q      <= '0;
            respValid_q  <= 1'b0;
            respCode_q   <= '0;
            busy_q       <= 1'b0;
            spurCnt_q    <= '0;
        end else begin
            parserPrev_q <= parser_error_in;
            if (status_valid_in && state_q != WAIT_ST && spurCnt_q != 8'hFF) begin
                spurCnt_q <= spurCnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    // The response pulse is shown while already in IDLE; ready returns after it.
                    if (respValid_q) begin
                        respValid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        reqReady_q  <= 1'b1;
                    end else if (reqReady_q && req_valid) begin
                        open_q     <= req_open;
                        destIp_q   <= req_dest_ip;
                        destPort_q <= req_dest_port;
                        flowId_q   <= req_client_flow_id;
                        qpNum_q    <= req_qp_num;
                        pKey_q     <= req_p_key;
                        qKey_q     <= req_q_key;
                        frame_q    <= {CMD_CONN_ID, 32'd0, req_conn_id};
                        en_q       <= 1'b1;
                        frameIdx_q <= 3'd1;
                        reqReady_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end else begin
                        reqReady_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (parserRise) begin
                        en_q       <= 1'b0;
                        frame_q    <= '0;
                        respCode_q <= RESP_PARSE_ERR;
                        state_q    <= RESP;
                    end else if (frame_q[66:64] == CMD_ENABLE) begin
                        en_q    <= 1'b0;
                        frame_q <= '0;
                        timer_q <= '0;
                        state_q <= WAIT_ST;
                    end else begin
                        frame_q    <= nextFrame_d;
                        frameIdx_q <= frameIdx_q + 3'd1;
                    end
                end
                WAIT_ST: begin
                    if (parserRise) begin
                        respCode_q <= RESP_PARSE_ERR;
                        state_q    <= RESP;
                    end else if (status_valid_in) begin
                        respCode_q <= status_error_in ? RESP_REJECTED : RESP_OK;
                        state_q    <= RESP;
                    end else if (timer_q == TIMER_LAST) begin
                        respCode_q <= RESP_TIMEOUT;
                        state_q    <= RESP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                RESP: begin
                    respValid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready            = reqReady_q;
    assign conn_setup_en_out    = en_q;
    assign conn_setup_frame_out = frame_q;
    assign resp_valid           = respValid_q;
    assign resp_code            = respCode_q;
    assign busy                 = busy_q;
    assign spurious_status_cnt  = spurCnt_q;

endmodule
